// File: rtl/csr_regfile.sv
// Accelerator CSR bank: config and control for the compute core, busy/done/error status, busy-cycle counter, level irq.
// Latency: read data is combinational from csr_addr; writes land at the strobe edge; start/abort/irq are registered (+1 cycle).
// Backpressure: none. Every csr_wen/csr_ren strobe is accepted in its own cycle.
module csr_regfile #(
  parameter int          CSR_ADDR_WIDTH = 8,
  parameter int          CSR_DATA_WIDTH = 32,
  parameter logic [31:0] VERSION_ID     = 32'h0001_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_wen,
  input  logic                      csr_ren,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  input  logic [CSR_DATA_WIDTH-1:0] csr_wdata,
  output logic [CSR_DATA_WIDTH-1:0] csr_rdata,
  output logic                      core_start,
  output logic                      core_abort,
  output logic [31:0]               cfg_src_addr,
  output logic [31:0]               cfg_dst_addr,
  output logic [15:0]               cfg_len,
  input  logic                      core_done,
  input  logic                      core_error,
  output logic                      irq
);

  localparam int WW = CSR_ADDR_WIDTH - 2;

  localparam logic [WW-1:0] OFF_CTRL    = WW'(0);
  localparam logic [WW-1:0] OFF_STATUS  = WW'(1);
  localparam logic [WW-1:0] OFF_SRC     = WW'(2);
  localparam logic [WW-1:0] OFF_DST     = WW'(3);
  localparam logic [WW-1:0] OFF_LEN     = WW'(4);
  localparam logic [WW-1:0] OFF_PERF    = WW'(5);
  localparam logic [WW-1:0] OFF_SCRATCH = WW'(6);
  localparam logic [WW-1:0] OFF_VERSION = WW'(7);

  logic [WW-1:0] word;
  logic          unused_bits;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_en_q, irq_en_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;
  logic        irq_q, irq_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [31:0] perf_q, perf_d;
  logic [31:0] scratch_q, scratch_d;

  logic wr_ctrl, wr_status, start_req, abort_req;

  // Byte-lane bits and the read strobe carry no information for this bank.
  assign unused_bits = ^{csr_ren, csr_addr[1:0]};

  assign word      = csr_addr[CSR_ADDR_WIDTH-1:2];
  assign wr_ctrl   = csr_wen && (word == OFF_CTRL);
  assign wr_status = csr_wen && (word == OFF_STATUS);
  // ABORT wins over START when both are written together.
  assign abort_req = wr_ctrl && csr_wdata[1];
  assign start_req = wr_ctrl && csr_wdata[0] && !csr_wdata[1];

  // Next-state: run/idle control, sticky status, counter and config registers.
  always_comb begin
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    irq_en_d  = irq_en_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    perf_d    = perf_q;
    scratch_d = scratch_q;

    if (busy_q) begin
      if (core_done || core_error || abort_req) busy_d = 1'b0;
      abort_d = abort_req;
      if (perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end else if (start_req) begin
      busy_d  = 1'b1;
      start_d = 1'b1;
      perf_d  = 32'd0;
    end

    // Software clear first so a same-cycle hardware set wins.
    if (wr_status && csr_wdata[1]) done_d = 1'b0;
    if (wr_status && csr_wdata[2]) err_d  = 1'b0;
    if (busy_q && core_done) done_d = 1'b1;
    if (busy_q && (core_error || start_req)) err_d = 1'b1;

    if (wr_ctrl) irq_en_d = csr_wdata[2];
    if (csr_wen && (word == OFF_SCRATCH)) scratch_d = csr_wdata[31:0];
    // Core configuration is frozen while a job runs.
    if (csr_wen && !busy_q) begin
      if (word == OFF_SRC) src_d = csr_wdata[31:0];
      if (word == OFF_DST) dst_d = csr_wdata[31:0];
      if (word == OFF_LEN) len_d = csr_wdata[15:0];
    end
  end

  // irq looks at the current sticky bits, so it trails them by one cycle.
  assign irq_d = irq_en_q && (done_q || err_q);

  // State registers with asynchronous clear; no abort pulse is produced by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      irq_q     <= 1'b0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      len_q     <= 16'd0;
      perf_q    <= 32'd0;
      scratch_q <= 32'd0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      irq_en_q  <= irq_en_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      irq_q     <= irq_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      perf_q    <= perf_d;
      scratch_q <= scratch_d;
    end
  end

  // Zero-latency read mux; unmapped offsets read as zero.
  always_comb begin
    csr_rdata = '0;
    case (word)
      OFF_CTRL:    csr_rdata = CSR_DATA_WIDTH'({irq_en_q, 2'b00});
      OFF_STATUS:  csr_rdata = CSR_DATA_WIDTH'({err_q, done_q, busy_q});
      OFF_SRC:     csr_rdata = CSR_DATA_WIDTH'(src_q);
      OFF_DST:     csr_rdata = CSR_DATA_WIDTH'(dst_q);
      OFF_LEN:     csr_rdata = CSR_DATA_WIDTH'(len_q);
      OFF_PERF:    csr_rdata = CSR_DATA_WIDTH'(perf_q);
      OFF_SCRATCH: csr_rdata = CSR_DATA_WIDTH'(scratch_q);
      OFF_VERSION: csr_rdata = CSR_DATA_WIDTH'(VERSION_ID);
      default:     csr_rdata = '0;
    endcase
  end

  assign core_start   = start_q;
  assign core_abort   = abort_q;
  assign irq          = irq_q;
  assign cfg_src_addr = src_q;
  assign cfg_dst_addr = dst_q;
  assign cfg_len      = len_q;

endmodule
